// File: rtl/quad_encoder_bank_if.sv
// quad_encoder_bank_if: encoder inputs, control strobes and register read port of quad_encoder_bank
interface quad_encoder_bank_if #(parameter int N_CH = 2);
  logic [N_CH-1:0] enc_a;
  logic [N_CH-1:0] enc_b;
  logic [N_CH-1:0] clear_pos;
  logic            clear_err;
  logic [7:0]      rd_addr;
  logic [31:0]     rd_data;
  logic            speed_valid;
  modport master (output enc_a, enc_b, clear_pos, clear_err, rd_addr, input rd_data, speed_valid);
  modport slave (input enc_a, enc_b, clear_pos, clear_err, rd_addr, output rd_data, speed_valid);
endinterface

// File: rtl/quad_encoder_bank.sv
// quad_encoder_bank: N-channel 4x quadrature decoder with position, windowed speed and register reads; QENC_GLITCH_FILTER_EN adds a 3-sample input majority filter
module quad_encoder_bank #(
  parameter int N_CH          = 2,
  parameter int CNT_W         = 32,
  parameter int WINDOW_CYCLES = 1_000_000,
  parameter int SPEED_OFFSET  = 1023
) (
  input logic clk,
  input logic reset,
  quad_encoder_bank_if.slave bus
);
  localparam int WW = $clog2(WINDOW_CYCLES);
`ifdef QENC_GLITCH_FILTER_EN
  localparam logic [2:0] WARM = 3'd5;
`else
  localparam logic [2:0] WARM = 3'd3;
`endif
  logic [N_CH-1:0] a_s1, a_s2, b_s1, b_s2, a_c, b_c, a_p, b_p, ca, cb, up, dn, ill, err;
  logic [2:0] warm;
  logic armed;
  logic [WW-1:0] wcnt;
  logic win_end;
  logic signed [CNT_W-1:0] pos [N_CH];
  logic signed [31:0] delta [N_CH];
  logic [31:0] speed [N_CH];
  logic [31:0] rd_nxt;
  function automatic logic [31:0] sat(input logic signed [31:0] d);
    logic signed [32:0] s;
    s = 33'(d) + 33'(SPEED_OFFSET);
    return (s[32] != s[31]) ? {s[32], {31{~s[32]}}} : s[31:0];
  endfunction
  always_ff @(posedge clk or posedge reset)
    if (reset) {a_s1, a_s2, b_s1, b_s2} <= '0;
    else begin
      a_s1 <= bus.enc_a;
      a_s2 <= a_s1;
      b_s1 <= bus.enc_b;
      b_s2 <= b_s1;
    end
`ifdef QENC_GLITCH_FILTER_EN
  logic [N_CH-1:0] a_d1, a_d2, b_d1, b_d2;
  always_ff @(posedge clk or posedge reset)
    if (reset) {a_d1, a_d2, b_d1, b_d2, a_c, b_c} <= '0;
    else begin
      a_d1 <= a_s2;
      a_d2 <= a_d1;
      b_d1 <= b_s2;
      b_d2 <= b_d1;
      a_c  <= (a_s2 & a_d1) | (a_s2 & a_d2) | (a_d1 & a_d2);
      b_c  <= (b_s2 & b_d1) | (b_s2 & b_d2) | (b_d1 & b_d2);
    end
`else
  assign a_c = a_s2;
  assign b_c = b_s2;
`endif
  // decoding stays off until the synchronizer pipeline holds real input levels
  assign armed   = warm == WARM;
  assign ca      = a_c ^ a_p;
  assign cb      = b_c ^ b_p;
  assign up      = armed ? (ca & ~cb & ~(a_p ^ b_c)) | (cb & ~ca & (a_c ^ b_p)) : '0;
  assign dn      = armed ? (ca & ~cb & (a_p ^ b_c)) | (cb & ~ca & ~(a_c ^ b_p)) : '0;
  assign ill     = armed ? ca & cb : '0;
  assign win_end = wcnt == WW'(WINDOW_CYCLES - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      a_p             <= '0;
      b_p             <= '0;
      warm            <= '0;
      wcnt            <= '0;
      err             <= '0;
      bus.speed_valid <= 1'b0;
      bus.rd_data     <= '1;
      for (int i = 0; i < N_CH; i++) begin
        pos[i]   <= '0;
        delta[i] <= '0;
        speed[i] <= 32'(SPEED_OFFSET);
      end
    end else begin
      a_p             <= a_c;
      b_p             <= b_c;
      if (!armed) warm <= warm + 1'b1;
      wcnt            <= win_end ? '0 : wcnt + 1'b1;
      bus.speed_valid <= win_end;
      err             <= (err & ~{N_CH{bus.clear_err}}) | ill;
      bus.rd_data     <= rd_nxt;
      for (int i = 0; i < N_CH; i++) begin
        pos[i]   <= bus.clear_pos[i] ? '0 : up[i] ? pos[i] + 1'b1 : dn[i] ? pos[i] - 1'b1 : pos[i];
        delta[i] <= (win_end ? 32'sd0 : delta[i]) + (up[i] ? 32'sd1 : dn[i] ? -32'sd1 : 32'sd0);
        if (win_end) speed[i] <= sat(delta[i]);
      end
    end
  always_comb begin
    rd_nxt = '1;
    for (int i = 0; i < N_CH; i++) begin
      if (bus.rd_addr == 8'(i)) rd_nxt = speed[i];
      if (bus.rd_addr == 8'(N_CH + i)) rd_nxt = 32'(pos[i]);
    end
    if (bus.rd_addr == 8'hFE) rd_nxt = 32'(err);
    if (bus.rd_addr == 8'hFF) rd_nxt = {8'(N_CH), 8'(CNT_W), 16'hE2C0};
  end
endmodule

// File: tb/tb_quad_encoder_bank.sv
// tb_quad_encoder_bank: directed checks of decode, speed windows, errors, clears and reset for quad_encoder_bank
module tb_quad_encoder_bank;
  localparam int N = 2;
  localparam int W = 100;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  int idx [N];
  always #10 clk = ~clk;
  quad_encoder_bank_if #(.N_CH(N)) bus ();
  quad_encoder_bank #(.N_CH(N), .CNT_W(32), .WINDOW_CYCLES(W), .SPEED_OFFSET(1023)) dut (
    .clk(clk), .reset(reset), .bus(bus));
  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic set_enc(int ch);
    bus.enc_a[ch] = (idx[ch] == 1 || idx[ch] == 2);
    bus.enc_b[ch] = (idx[ch] == 2 || idx[ch] == 3);
  endtask
  task automatic step(int ch, int dir, int hold);
    idx[ch] = (idx[ch] + dir + 4) % 4;
    set_enc(ch);
    repeat (hold) @(negedge clk);
  endtask
  task automatic rd_chk(string tag, logic [7:0] a, logic [31:0] exp);
    bus.rd_addr = a;
    @(negedge clk);
    check(tag, bus.rd_data, exp);
  endtask
  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.speed_valid && n < 400);
  endtask
  initial begin
    int n;
    bus.enc_a = '0;
    bus.enc_b = '0;
    bus.clear_pos = '0;
    bus.clear_err = 1'b0;
    bus.rd_addr = 8'hFF;
    idx[0] = 0;
    idx[1] = 0;
    repeat (3) @(negedge clk);
    check("rst_rd_data", bus.rd_data, 32'hFFFF_FFFF);
    check("rst_speed_valid", 32'(bus.speed_valid), 0);
    reset = 1'b0;
    rd_chk("id_reg", 8'hFF, 32'h0220_E2C0);
    rd_chk("speed0_rst", 8'd0, 1023);
    rd_chk("pos0_rst", 8'd2, 0);
    rd_chk("err_rst", 8'hFE, 0);
    rd_chk("unmapped_4", 8'd4, 32'hFFFF_FFFF);
    for (int i = 0; i < 8; i++) step(0, 1, 40);
    rd_chk("pos0_fwd8", 8'd2, 8);
    rd_chk("err_fwd8", 8'hFE, 0);
    for (int i = 0; i < 5; i++) step(1, -1, 6);
    repeat (4) @(negedge clk);
    rd_chk("pos1_rev5", 8'd3, 32'hFFFF_FFFB);
    rd_chk("pos0_hold", 8'd2, 8);
    wait_valid(n);
    check("sv_align", 32'(bus.speed_valid), 1);
    for (int i = 0; i < 12; i++) step(0, 1, 6);
    wait_valid(n);
    check("sv_window12", 32'(bus.speed_valid), 1);
    bus.rd_addr = 8'd0;
    @(negedge clk);
    check("sv_one_cycle", 32'(bus.speed_valid), 0);
    check("speed0_12", bus.rd_data, 1035);
    rd_chk("speed1_idle", 8'd1, 1023);
    wait_valid(n);
    rd_chk("speed0_empty", 8'd0, 1023);
    idx[0] = 2;
    set_enc(0);
    repeat (6) @(negedge clk);
    rd_chk("pos0_illegal", 8'd2, 20);
    rd_chk("err_illegal", 8'hFE, 1);
    repeat (5) @(negedge clk);
    rd_chk("err_sticky", 8'hFE, 1);
    bus.clear_err = 1'b1;
    @(negedge clk);
    bus.clear_err = 1'b0;
    rd_chk("err_cleared", 8'hFE, 0);
    bus.clear_pos[0] = 1'b1;
    @(negedge clk);
    bus.clear_pos[0] = 1'b0;
    rd_chk("pos0_clear", 8'd2, 0);
    for (int i = 0; i < 7; i++) step(0, 1, 6);
    rd_chk("pos0_7", 8'd2, 7);
    step(0, 1, 2);
    bus.clear_pos[0] = 1'b1;
    @(negedge clk);
    bus.clear_pos[0] = 1'b0;
    repeat (3) @(negedge clk);
    rd_chk("pos0_clear_wins", 8'd2, 0);
    wait_valid(n);
    repeat (97) @(negedge clk);
    step(0, 1, 0);
    wait_valid(n);
    check("sv_boundary_lat", n, 3);
    rd_chk("speed0_boundary_excl", 8'd0, 1023);
    wait_valid(n);
    rd_chk("speed0_boundary_next", 8'd0, 1024);
    rd_chk("pos0_boundary", 8'd2, 1);
    while (idx[0] != 2) step(0, 1, 6);
    bus.clear_pos[0] = 1'b1;
    @(negedge clk);
    bus.clear_pos[0] = 1'b0;
    for (int i = 0; i < 20; i++) step(0, 1, 6);
    rd_chk("pos0_20", 8'd2, 20);
    repeat (30) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rd_data_in_reset", bus.rd_data, 32'hFFFF_FFFF);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    wait_valid(n);
    check("first_sv_after_reset", n, W);
    rd_chk("pos0_after_reset", 8'd2, 0);
    rd_chk("pos1_after_reset", 8'd3, 0);
    rd_chk("err_after_reset", 8'hFE, 0);
    rd_chk("addr_0x40", 8'h40, 32'hFFFF_FFFF);
    rd_chk("speed0_after_reset", 8'd0, 1023);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/quad_encoder_bank.md
QUAD_ENCODER_BANK -- requirements
Module: quad_encoder_bank

Interface
REQ-001 SHALL have parameter N_CH, default 2: number of quadrature channels (1..8).
REQ-002 SHALL have parameter CNT_W, default 32: position counter width (16..32).
REQ-003 SHALL have parameter WINDOW_CYCLES, default 1_000_000: speed sample window in clk cycles (>=16).
REQ-004 SHALL have parameter SPEED_OFFSET, default 1023: bias added to each speed sample so that reverse motion stays positive.
REQ-005 SHALL have port clk, input, 1: system clock (50 MHz).
REQ-006 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port enc_a, input, N_CH: channel A per encoder (asynchronous).
REQ-008 SHALL have port enc_b, input, N_CH: channel B per encoder (asynchronous).
REQ-009 SHALL have port clear_pos, input, N_CH: per-channel position clear, one-cycle pulse.
REQ-010 SHALL have port clear_err, input, 1: clears all sticky error flags.
REQ-011 SHALL have port rd_addr, input, 8: register read address (SPI Data_Addr).
REQ-012 SHALL have port rd_data, output, 32: registered read data (SPI Data_Read).
REQ-013 SHALL have port speed_valid, output, 1: one-cycle pulse when new speed samples are latched.

Function
REQ-014 SHALL pass each enc_a/enc_b bit through a 2-FF synchronizer, then hold a previous-state register; all decode SHALL use the synchronized signals on clk only (no edge-clocked logic).
REQ-015 SHALL decode 4x: (A,B) transitions 00->10->11->01->00 (A leads B) count +1 per step; the reverse sequence counts -1.
REQ-016 SHALL treat a transition where A and B change in the same cycle as illegal: no count, and set sticky err[ch].
REQ-017 SHALL hold a signed CNT_W-bit position per channel, updated in the cycle after the synchronized transition; wrap-around modulo 2^CNT_W without saturation.
REQ-018 SHALL give clear_pos[ch] priority over a same-cycle count: position becomes 0 and that step is discarded.
REQ-019 SHALL keep a signed 32-bit window delta per channel and a shared window counter running 0..WINDOW_CYCLES-1.
REQ-020 SHALL, on the cycle with window counter == WINDOW_CYCLES-1, latch speed[ch] = delta[ch] + SPEED_OFFSET, load delta with that cycle's step (0 or +/-1, so no step is lost at the boundary), and pulse speed_valid.
REQ-021 SHALL saturate speed[ch] to the 32-bit signed range instead of wrapping.
REQ-022 SHALL map reads: addr ch -> speed[ch]; addr N_CH+ch -> position[ch] sign-extended to 32 bits; addr 0xFE -> {zero-fill, err[N_CH-1:0]}; addr 0xFF -> {N_CH[7:0], CNT_W[7:0], 16'hE2C0}; all other addresses -> 32'hFFFF_FFFF.
REQ-023 SHALL register rd_data: value reflects rd_addr sampled one clk edge earlier.
REQ-024 SHALL set err flags only via REQ-016; clear_err clears all flags, and a same-cycle illegal transition keeps its flag set (set wins).

Reset
REQ-025 SHALL, while reset is high, drive position, delta and window counter to 0, speed to SPEED_OFFSET, err to 0, speed_valid to 0 and rd_data to 32'hFFFF_FFFF, with synchronizer and previous-state registers set to 00.
REQ-026 SHALL, after reset deasserts, ignore the first synchronized sample (previous-state is loaded, no count) so that the startup encoder level never produces a step or error.
REQ-027 SHALL, on reset mid-window, discard partial deltas; the first speed_valid after reset comes WINDOW_CYCLES cycles after deassertion.

Configuration
REQ-028 SHALL, with macro QENC_GLITCH_FILTER_EN defined, insert per-input a 3-sample majority filter after the synchronizer (+2 cycles latency, pulses shorter than 2 cycles rejected); without it, the decoder uses the synchronizer output directly.

Verification
REQ-029 SHALL cover: 8 forward quadrature steps on ch0, 40 cycles per step -> position[0] reads 8 at addr N_CH, err=0.
REQ-030 SHALL cover: 5 reverse steps from reset on ch1 -> position[1] reads 32'hFFFF_FFFB.
REQ-031 SHALL cover: WINDOW_CYCLES=100, 12 forward steps inside one window -> speed_valid pulse, speed[0]=1035; an empty next window -> 1023.
REQ-032 SHALL cover: A and B toggled in the same cycle on ch0 -> no position change, addr 0xFE reads 1; clear_err -> reads 0.
REQ-033 SHALL cover: clear_pos[0] coincident with a forward step at position 7 -> position 0; a step exactly on the window-end cycle -> counted in the next window.
REQ-034 SHALL cover: reset asserted mid-window with position 20 and encoder held at 11 -> rd_data 32'hFFFF_FFFF during reset, position 0 after reset, no err; addr 0x40 -> 32'hFFFF_FFFF.
